mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mips_pkg.sv | 55 +++++
 rtl/alu_decoder.sv | 26 ++
 rtl/mc_controller.sv | 158 +++++++++++++++
 tb/tb_mc_controller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: ALU operation
// codes (also used by the ALU), instruction opcode/funct fields, datapath
// mux selects and the controller state enumeration.
package mips_pkg;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    // instruction[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // instruction[5:0] for R-type
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU B operand select
    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    // next-PC select
    localparam logic [1:0] PC_SRC_ALU     = 2'b00;
    localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_READ,
        MEM_WB,
        MEM_WRITE,
        R_EXEC,
        R_WB,
        I_EXEC,
        I_WB,
        BRANCH,
        JUMP,
        HALT
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// R-type function decoder: maps funct to an ALU operation. Unknown funct
// codes fall back to Add and raise the illegal flag.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       illegal
);

    // funct -> ALU operation lookup
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS controller: Moore FSM driving the datapath enables and
// mux selects. pc_write_cond is combined with the zero flag in the datapath.
// Build option ILLEGAL_TRAP_EN: unknown opcode or funct traps into HALT
// (halted=1, all enables off until reset). Without it, unknown opcodes act
// as a 2-cycle NOP and unknown funct codes execute as Add.
module mc_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alu_op,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic       halted,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src
);

    state_t     state;
    state_t     next_state;
    logic [2:0] r_alu_op;
    logic       funct_illegal;

    // zero is consumed by the datapath branch qualifier, not by the FSM
    logic unused;
    assign unused = ^{zero, funct_illegal};

    alu_decoder u_alu_decoder (
        .funct   (funct),
        .alu_op  (r_alu_op),
        .illegal (funct_illegal)
    );

    // state register; reset lands in FETCH without waiting for a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (!rst_n) state <= FETCH;
        else        state <= next_state;
    end

    // next-state and Moore outputs, decoded from the current state
    always_comb begin
        next_state    = state;
        alu_op        = ALU_ADD;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        halted        = 1'b0;
        alu_src_b     = SRC_B_REG;
        pc_src        = PC_SRC_ALU;
        case (state)
            FETCH: begin
                mem_read   = 1'b1;
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                next_state = DECODE;
            end
            DECODE: begin
                // precompute the branch target while the opcode is dispatched
                alu_src_b = SRC_B_IMM_SH2;
                case (opcode)
                    OP_LW, OP_SW: next_state = MEM_ADDR;
                    OP_RTYPE:     next_state = R_EXEC;
                    OP_ADDI:      next_state = I_EXEC;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
`ifdef ILLEGAL_TRAP_EN
                    default:      next_state = HALT;
`else
                    default:      next_state = FETCH;
`endif
                endcase
            end
            MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_IMM;
                next_state = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                mem_read   = 1'b1;
                i_or_d     = 1'b1;
                next_state = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next_state = FETCH;
            end
            MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                next_state = FETCH;
            end
            R_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = r_alu_op;
`ifdef ILLEGAL_TRAP_EN
                next_state = funct_illegal ? HALT : R_WB;
`else
                next_state = R_WB;
`endif
            end
            R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                next_state = FETCH;
            end
            I_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_IMM;
                next_state = I_WB;
            end
            I_WB: begin
                reg_write  = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = PC_SRC_ALU_OUT;
                next_state    = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_src     = PC_SRC_JUMP;
                next_state = FETCH;
            end
            HALT: begin
`ifdef ILLEGAL_TRAP_EN
                halted     = 1'b1;
`endif
                next_state = HALT;
            end
            default: next_state = FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed testbench for mc_controller: walks each instruction class through
// its state sequence and compares the full output vector every cycle against
// hand-tabulated per-state values. Honours ILLEGAL_TRAP_EN like the design.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] alu_op;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a, halted;
    logic [1:0] alu_src_b, pc_src;

    int checks   = 0;
    int failures = 0;

    typedef enum int {
        T_FETCH, T_DECODE, T_MEM_ADDR, T_MEM_READ, T_MEM_WB, T_MEM_WRITE,
        T_R_EXEC, T_R_WB, T_I_EXEC, T_I_WB, T_BRANCH, T_JUMP, T_HALT
    } tst_e;

    tst_e exp_q[$];

    mc_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .alu_op        (alu_op),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .halted        (halted),
        .alu_src_b     (alu_src_b),
        .pc_src        (pc_src)
    );

    always #5 clk = ~clk;

    // observed vector: pw pwc iord mr mw irw rw rd m2r asa halt asb[2] psrc[2] aop[3]
    logic [17:0] obs;
    assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  reg_write, reg_dst, mem_to_reg, alu_src_a, halted,
                  alu_src_b, pc_src, alu_op};

    // expected outputs per state, tabulated from the requirements
    function automatic logic [17:0] expv(tst_e st, logic [2:0] rop);
        logic pw, pwc, iod, mr, mw, irw, rw, rd, m2r, asa, hlt;
        logic [1:0] asb, ps;
        logic [2:0] aop;
        {pw, pwc, iod, mr, mw, irw, rw, rd, m2r, asa, hlt} = '0;
        asb = 2'b00;
        ps  = 2'b00;
        aop = 3'b000;
        case (st)
            T_FETCH:     begin pw = 1; mr = 1; irw = 1; asb = 2'b01; end
            T_DECODE:    begin asb = 2'b11; end
            T_MEM_ADDR:  begin asa = 1; asb = 2'b10; end
            T_MEM_READ:  begin mr = 1; iod = 1; end
            T_MEM_WB:    begin rw = 1; m2r = 1; end
            T_MEM_WRITE: begin mw = 1; iod = 1; end
            T_R_EXEC:    begin asa = 1; aop = rop; end
            T_R_WB:      begin rw = 1; rd = 1; end
            T_I_EXEC:    begin asa = 1; asb = 2'b10; end
            T_I_WB:      begin rw = 1; end
            T_BRANCH:    begin asa = 1; aop = 3'b001; pwc = 1; ps = 2'b01; end
            T_JUMP:      begin pw = 1; ps = 2'b10; end
            T_HALT:      begin hlt = 1; end
            default:     begin end
        endcase
        return {pw, pwc, iod, mr, mw, irw, rw, rd, m2r, asa, hlt, asb, ps, aop};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // apply an instruction and step through exp_q, one state per rising edge
    task automatic run_seq(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic [2:0] rop);
        opcode = op;
        funct  = fn;
        zero   = z;
        foreach (exp_q[i]) begin
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", tag, i), {14'd0, obs}, {14'd0, expv(exp_q[i], rop)});
        end
    endtask

    // asynchronous reset pulse placed between clock edges
    task automatic pulse_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check(tag, {14'd0, obs}, {14'd0, expv(T_FETCH, 3'b000)});
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] fn_tab [5];
        logic [2:0] op_tab [5];
        fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        op_tab = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};

        rst_n  = 1'b0;
        opcode = 6'b000000;
        funct  = 6'b000000;
        zero   = 1'b0;

        // reset state before any clock edge, then held across an edge
        #2 check("reset_noclk", {14'd0, obs}, {14'd0, expv(T_FETCH, 3'b000)});
        @(posedge clk); #1;
        check("reset_held", {14'd0, obs}, {14'd0, expv(T_FETCH, 3'b000)});
        #2 rst_n = 1'b1;

        // lw: 5 cycles
        exp_q = '{T_DECODE, T_MEM_ADDR, T_MEM_READ, T_MEM_WB, T_FETCH};
        run_seq("lw", 6'b100011, 6'b000000, 1'b0, 3'b000);

        // sw: 4 cycles
        exp_q = '{T_DECODE, T_MEM_ADDR, T_MEM_WRITE, T_FETCH};
        run_seq("sw", 6'b101011, 6'b000000, 1'b0, 3'b000);

        // R-type, each known funct: 4 cycles
        for (int k = 0; k < 5; k++) begin
            exp_q = '{T_DECODE, T_R_EXEC, T_R_WB, T_FETCH};
            run_seq($sformatf("rtype_fn%0d", k), 6'b000000, fn_tab[k], 1'b0, op_tab[k]);
        end

        // addi: 4 cycles
        exp_q = '{T_DECODE, T_I_EXEC, T_I_WB, T_FETCH};
        run_seq("addi", 6'b001000, 6'b000000, 1'b0, 3'b000);

        // beq, taken and not taken: 3 cycles, outputs independent of zero
        exp_q = '{T_DECODE, T_BRANCH, T_FETCH};
        run_seq("beq_z1", 6'b000100, 6'b000000, 1'b1, 3'b000);
        exp_q = '{T_DECODE, T_BRANCH, T_FETCH};
        run_seq("beq_z0", 6'b000100, 6'b000000, 1'b0, 3'b000);

        // j: 3 cycles
        exp_q = '{T_DECODE, T_JUMP, T_FETCH};
        run_seq("j", 6'b000010, 6'b000000, 1'b0, 3'b000);

        // reset while in MEM_READ abandons the lw; next edge is a FETCH cycle
        exp_q = '{T_DECODE, T_MEM_ADDR, T_MEM_READ};
        run_seq("lw_pre_rst", 6'b100011, 6'b000000, 1'b0, 3'b000);
        pulse_reset("rst_mid_memread");
        check("rst_release_fetch", {14'd0, obs}, {14'd0, expv(T_FETCH, 3'b000)});
        exp_q = '{T_DECODE, T_MEM_ADDR, T_MEM_READ, T_MEM_WB, T_FETCH};
        run_seq("lw_post_rst", 6'b100011, 6'b000000, 1'b0, 3'b000);

`ifdef ILLEGAL_TRAP_EN
        // unknown funct traps after R_EXEC (which executes as Add)
        exp_q = '{T_DECODE, T_R_EXEC, T_HALT, T_HALT};
        run_seq("bad_funct", 6'b000000, 6'b111111, 1'b0, 3'b000);
        pulse_reset("rst_from_halt_fn");

        // unknown opcode traps and stays halted for 10 more cycles
        exp_q = '{T_DECODE};
        repeat (11) exp_q.push_back(T_HALT);
        run_seq("bad_opcode", 6'b111111, 6'b000000, 1'b0, 3'b000);
        pulse_reset("rst_from_halt_op");
        exp_q = '{T_DECODE, T_JUMP, T_FETCH};
        run_seq("j_after_halt", 6'b000010, 6'b000000, 1'b0, 3'b000);
`else
        // unknown funct completes as Add through R_WB
        exp_q = '{T_DECODE, T_R_EXEC, T_R_WB, T_FETCH};
        run_seq("bad_funct", 6'b000000, 6'b111111, 1'b0, 3'b000);

        // unknown opcode is a 2-cycle NOP
        exp_q = '{T_DECODE, T_FETCH};
        run_seq("bad_opcode", 6'b111111, 6'b000000, 1'b0, 3'b000);
        exp_q = '{T_DECODE, T_FETCH};
        run_seq("bad_opcode2", 6'b110000, 6'b000000, 1'b0, 3'b000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
